// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sort_pkg
// Description : Shared types and helpers for the sort_unscatter block:
//               FSM state encoding, tag-width helper and counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package sort_pkg;

  // Scatter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCATTER = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Element counter width; covers vectors of up to 256 elements.
  localparam int CNT_W = 8;

  // Tag width for a vector of n elements, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sort_unscatter_slot_tracker.sv
`default_nettype none
// ============================================================================
// Module      : sort_unscatter_slot_tracker
// Description : Tracks which output slots have already been written for the
//               current vector. For each presented tag it grants the write
//               only if the tag is in range and its slot is still empty
//               (first write wins), and flags an error otherwise.
// Revision    : 1.0 - initial release
// Ports       :
//   i_clk   in   clock
//   i_rst_n in   asynchronous active-low reset
//   clear   in   start of a new vector, empties the filled mask
//   valid   in   a tag is presented this cycle
//   tag     in   IDX_W  destination slot of the current element
//   wr_en   out  write the element into slot 'tag'
//   err     out  tag is out of range or its slot is already filled
// ============================================================================
module sort_unscatter_slot_tracker
  import sort_pkg::*;
#(
  parameter  int NUM_VALS = 5,
  localparam int IDX_W    = idx_w(NUM_VALS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             clear,
  input  logic             valid,
  input  logic [IDX_W-1:0] tag,
  output logic             wr_en,
  output logic             err
);

  logic [NUM_VALS-1:0] filled;
  logic                in_range;

  // One extra bit so the compare also works when NUM_VALS is a power of two.
  assign in_range = {1'b0, tag} < (IDX_W+1)'(NUM_VALS);
  assign wr_en    = valid && in_range && !filled[tag];
  assign err      = valid && !wr_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      filled <= '0;
    end else if (clear) begin
      filled <= '0;
    end else if (wr_en) begin
      filled[tag] <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sort_unscatter.sv
`default_nettype none
// ============================================================================
// Module      : sort_unscatter
// Description : Inverse-permutation engine. Captures a sorted vector with its
//               original-position tags and scatters one element per cycle
//               back to its pre-sort slot, then holds the restored vector
//               until the consumer accepts it.
// Revision    : 1.0 - initial release
// Options     : SORT_UNSCATTER_ERR_CHECK_EN - when defined, duplicate tags are
//               resolved first-write-wins and flagged on o_err together with
//               out-of-range tags. When undefined, the last in-range write
//               wins and o_err is tied low.
// Ports       :
//   i_clk    in   clock
//   i_rst_n  in   asynchronous active-low reset
//   i_valid  in   input vector valid
//   o_ready  out  block can accept a vector
//   i_data   in   NUM_VALS*SIZE  sorted elements, element k at [k*SIZE+:SIZE]
//   i_idx    in   NUM_VALS*IDX_W original slot of element k
//   o_valid  out  restored vector valid
//   i_ready  in   downstream accepts
//   o_data   out  NUM_VALS*SIZE  restored vector, slot p at [p*SIZE+:SIZE]
//   o_err    out  tag-set error for the vector on o_data
// ============================================================================
module sort_unscatter
  import sort_pkg::*;
#(
  parameter  int NUM_VALS = 5,
  parameter  int SIZE     = 16,
  localparam int IDX_W    = idx_w(NUM_VALS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [NUM_VALS*SIZE-1:0]  i_data,
  input  logic [NUM_VALS*IDX_W-1:0] i_idx,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [NUM_VALS*SIZE-1:0]  o_data,
  output logic                      o_err
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SIZE-1:0]  elem     [NUM_VALS];
  logic [IDX_W-1:0] tag      [NUM_VALS];
  logic [SIZE-1:0]  slot_buf [NUM_VALS];

  logic             accept;
  logic             scatter;
  logic [IDX_W-1:0] cur_tag;
  logic [SIZE-1:0]  cur_elem;
  logic             wr_en;

  assign accept   = (state == IDLE) && i_valid && o_ready;
  assign scatter  = (state == SCATTER);
  assign cur_tag  = tag[cnt[IDX_W-1:0]];
  assign cur_elem = elem[cnt[IDX_W-1:0]];

`ifdef SORT_UNSCATTER_ERR_CHECK_EN
  logic slot_err;
  logic err_q;

  sort_unscatter_slot_tracker #(
    .NUM_VALS (NUM_VALS)
  ) u_slot_tracker (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clear   (accept),
    .valid   (scatter),
    .tag     (cur_tag),
    .wr_en   (wr_en),
    .err     (slot_err)
  );

  assign o_err = err_q;

  // Error is sticky for the whole vector and cleared on the next accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (scatter && slot_err) begin
      err_q <= 1'b1;
    end
  end
`else
  logic in_range;

  // Without the filled mask every in-range write lands; out-of-range tags
  // are still dropped so the buffer index never leaves the array.
  assign in_range = {1'b0, cur_tag} < (IDX_W+1)'(NUM_VALS);
  assign wr_en    = scatter && in_range;
  assign o_err    = 1'b0;
`endif

  // The slot buffer is a register, so o_data is a registered output.
  always_comb begin
    o_data = '0;
    for (int p = 0; p < NUM_VALS; p++) begin
      o_data[p*SIZE +: SIZE] = slot_buf[p];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      o_ready <= 1'b0;
      o_valid <= 1'b0;
      cnt     <= '0;
      for (int k = 0; k < NUM_VALS; k++) begin
        elem[k]     <= '0;
        tag[k]      <= '0;
        slot_buf[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            for (int k = 0; k < NUM_VALS; k++) begin
              elem[k]     <= i_data[k*SIZE +: SIZE];
              tag[k]      <= i_idx[k*IDX_W +: IDX_W];
              slot_buf[k] <= '0;
            end
            cnt     <= '0;
            o_ready <= 1'b0;
            state   <= SCATTER;
          end else begin
            // Also raises o_ready on the first cycle after reset release.
            o_ready <= 1'b1;
          end
        end

        SCATTER: begin
          if (wr_en) begin
            slot_buf[cur_tag] <= cur_elem;
          end
          // The last element is written on the same edge that enters DONE.
          if (cnt == CNT_W'(NUM_VALS - 1)) begin
            o_valid <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end

        default: begin
          o_valid <= 1'b0;
          o_ready <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sort_unscatter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort_unscatter
// Description : Self-checking bench for sort_unscatter (NUM_VALS=5, SIZE=16).
//               Expected vectors are queued when a vector is driven and
//               popped when the block presents its result. Expectations
//               follow SORT_UNSCATTER_ERR_CHECK_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sort_unscatter;

  localparam int NV = 5;
  localparam int SZ = 16;
  localparam int IW = 3;

`ifdef SORT_UNSCATTER_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_ready = 1'b0;
  logic [NV*SZ-1:0] i_data = '0;
  logic [NV*IW-1:0] i_idx = '0;
  logic             o_ready;
  logic             o_valid;
  logic [NV*SZ-1:0] o_data;
  logic             o_err;

  typedef struct packed {
    logic [NV*SZ-1:0] data;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  sort_unscatter #(
    .NUM_VALS (NV),
    .SIZE     (SZ)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_idx   (i_idx),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NV*SZ-1:0] pack5(input int a0, input int a1, input int a2,
                                             input int a3, input int a4);
    return {SZ'(a4), SZ'(a3), SZ'(a2), SZ'(a1), SZ'(a0)};
  endfunction

  function automatic logic [NV*IW-1:0] tags5(input int t0, input int t1, input int t2,
                                             input int t3, input int t4);
    return {IW'(t4), IW'(t3), IW'(t2), IW'(t1), IW'(t0)};
  endfunction

  // Reference scatter used for the randomised vectors.
  function automatic void model(input logic [NV*SZ-1:0] d, input logic [NV*IW-1:0] ix,
                                output logic [NV*SZ-1:0] od, output logic oe);
    logic [NV-1:0] filled;
    int t;
    od = '0;
    oe = 1'b0;
    filled = '0;
    for (int k = 0; k < NV; k++) begin
      t = int'(ix[k*IW +: IW]);
      if (t >= NV) begin
        oe = oe | ERR_EN;
      end else if (ERR_EN && filled[t]) begin
        oe = 1'b1;
      end else begin
        od[t*SZ +: SZ] = d[k*SZ +: SZ];
        filled[t] = 1'b1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for o_ready, presents the vector for exactly one accept edge and
  // queues its expected result. Returns just after the accept edge.
  task automatic push_vec(input logic [NV*SZ-1:0] d, input logic [NV*IW-1:0] ix,
                          input logic [NV*SZ-1:0] exp_d, input logic exp_e);
    exp_t e;
    int   n = 0;
    while (!o_ready && n < 30) begin
      tick();
      n++;
    end
    check("ready_wait", o_ready, 1);
    i_valid = 1'b1;
    i_data  = d;
    i_idx   = ix;
    e.data  = exp_d;
    e.err   = exp_e;
    sb.push_back(e);
    tick();
    i_valid = 1'b0;
  endtask

  // Called straight after push_vec: checks latency, holds off i_ready for
  // 'stall' cycles while checking the held result, then hands off.
  task automatic collect(input string tag, input int stall);
    exp_t e;
    int   n = 0;
    while (!o_valid && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, NV);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb[0];
    for (int s = 0; s < stall; s++) begin
      check({tag, "_hold_valid"}, o_valid, 1);
      check({tag, "_hold_ready"}, o_ready, 0);
      check({tag, "_hold_data"}, o_data, e.data);
      check({tag, "_hold_err"}, o_err, e.err);
      tick();
    end
    void'(sb.pop_front());
    check({tag, "_data"}, o_data, e.data);
    check({tag, "_err"}, o_err, e.err);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check({tag, "_valid_drop"}, o_valid, 0);
    check({tag, "_ready_back"}, o_ready, 1);
  endtask

  initial begin
    exp_t             e;
    logic [NV*SZ-1:0] md;
    logic             me;
    int               n;
    int               p [NV];
    int               tmp;
    int               j;
    logic [NV*SZ-1:0] rd;

    // Reset state
    #3;
    check("rst_ready", o_ready, 0);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_err", o_err, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", o_ready, 1);

    // Valid permutation
    push_vec(pack5(50, 40, 30, 20, 10), tags5(2, 0, 4, 1, 3),
             pack5(40, 20, 50, 10, 30), 1'b0);
    collect("perm", 0);

    // Backpressure: 7 stalled cycles in DONE
    push_vec(pack5(100, 200, 300, 400, 500), tags5(4, 3, 2, 1, 0),
             pack5(500, 400, 300, 200, 100), 1'b0);
    collect("bp", 7);

    // Duplicate tag
    if (ERR_EN) md = pack5(7, 9, 6, 5, 0);
    else        md = pack5(7, 8, 6, 5, 0);
    push_vec(pack5(9, 8, 7, 6, 5), tags5(1, 1, 0, 2, 3), md, ERR_EN);
    collect("dup", 0);

    // Out-of-range tag
    push_vec(pack5(1, 2, 3, 4, 5), tags5(0, 1, 2, 3, 7), pack5(1, 2, 3, 4, 0), ERR_EN);
    collect("oor", 0);

    // Reset in the middle of SCATTER (cnt==2), abandoned vector fills slots 4,3
    push_vec(pack5(11, 22, 33, 44, 55), tags5(4, 3, 2, 1, 0),
             pack5(55, 44, 33, 22, 11), 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_ready", o_ready, 0);
    check("midrst_valid", o_valid, 0);
    check("midrst_data", o_data, 0);
    check("midrst_err", o_err, 0);
    sb.delete();
    #3;
    rst_n = 1'b1;
    tick();
    check("midrst_ready_back", o_ready, 1);
    push_vec(pack5(6, 7, 8, 9, 10), tags5(0, 1, 2, 3, 7), pack5(6, 7, 8, 9, 0), ERR_EN);
    collect("post_rst", 0);

    // Back-to-back with i_valid held high and i_ready high
    i_ready = 1'b1;
    push_vec(pack5(1, 2, 3, 4, 5), tags5(1, 2, 3, 4, 0), pack5(5, 1, 2, 3, 4), 1'b0);
    i_valid = 1'b1;
    i_data  = pack5(60, 70, 80, 90, 99);
    i_idx   = tags5(3, 4, 0, 1, 2);
    e.data  = pack5(80, 90, 99, 60, 70);
    e.err   = 1'b0;
    sb.push_back(e);
    n = 0;
    while (!o_valid && n < 30) begin
      tick();
      n++;
    end
    check("b2b_a_latency", n, NV);
    e = sb.pop_front();
    check("b2b_a_data", o_data, e.data);
    check("b2b_a_ready_in_done", o_ready, 0);
    tick();
    check("b2b_idle_valid", o_valid, 0);
    check("b2b_idle_ready", o_ready, 1);
    tick();
    check("b2b_b_accepted", o_ready, 0);
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 30) begin
      tick();
      n++;
    end
    check("b2b_b_latency", n, NV);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("b2b_b_data", o_data, e.data);
      check("b2b_b_err", o_err, e.err);
    end else begin
      check("b2b_sb_empty", 0, 1);
    end
    tick();
    i_ready = 1'b0;
    check("b2b_b_drop", o_valid, 0);

    // Random permutations, some with a forced duplicate
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NV; i++) p[i] = i;
      for (int i = NV - 1; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        tmp = p[i];
        p[i] = p[j];
        p[j] = tmp;
      end
      if (r >= 4) p[4] = p[0];
      rd = '0;
      for (int i = 0; i < NV; i++) rd[i*SZ +: SZ] = SZ'($urandom);
      model(rd, tags5(p[0], p[1], p[2], p[3], p[4]), md, me);
      push_vec(rd, tags5(p[0], p[1], p[2], p[3], p[4]), md, me);
      collect("rand", r % 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
